// File: rtl/fetch_pc_unit.sv
// Program counter and fetch steering with static predict-taken and EX-driven mispredict redirect.
// Optional predict-taken steering is compiled in with `define FETCH_PREDICT_TAKEN_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] TEXT_LIMIT = 32'h0000_07FC,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch,
    input  logic [31:0]      target_offset,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic             resolve_predicted,
    input  logic [31:0]      resolve_target,
    input  logic [31:0]      resolve_pc_plus4,
    output logic [31:0]      address,
    output logic [31:0]      pc_plus4,
    output logic             predicted,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state;
    state_t      stateNext;
    logic [31:0] addressNext;
    logic [31:0] seqPc;
    logic [31:0] redirectPc;
    logic        mispredict;
    logic        unusedBits;

    assign pc_plus4 = address + 32'd4;
    assign halted   = (state == HALT);

`ifdef FETCH_PREDICT_TAKEN_EN
    assign predicted  = branch & ~halted & (state == RUN);
    assign seqPc      = pc_plus4 + (predicted ? {target_offset[29:0], 2'b00} : 32'd0);
    assign unusedBits = ^target_offset[31:30];
`else
    // Without prediction every taken branch is caught later as a mispredict.
    assign predicted  = 1'b0;
    assign seqPc      = pc_plus4;
    assign unusedBits = ^{branch, target_offset};
`endif

    assign mispredict = resolve_valid & (resolve_taken != resolve_predicted);
    assign redirectPc = {(resolve_taken ? resolve_target[31:2] : resolve_pc_plus4[31:2]), 2'b00};
    assign flush      = mispredict & (state != BOOT);

    always_comb begin
        stateNext   = state;
        addressNext = address;
        case (state)
            BOOT: stateNext = RUN;
            RUN: begin
                if (mispredict) begin
                    addressNext = redirectPc;
                end else if (!stall) begin
                    if (seqPc > TEXT_LIMIT) begin
                        stateNext = HALT;
                    end else begin
                        addressNext = seqPc;
                    end
                end
            end
            HALT: begin
                // Only an in-range redirect can leave HALT.
                if (mispredict && (redirectPc <= TEXT_LIMIT)) begin
                    addressNext = redirectPc;
                    stateNext   = RUN;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= BOOT;
            address          <= RESET_PC;
            mispredict_count <= '0;
        end else begin
            state   <= stateNext;
            address <= addressNext;
            if (flush && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized and directed bench for fetch_pc_unit against a behavioural next-PC model.
// Honours FETCH_PREDICT_TAKEN_EN the same way as the design.
module tb_fetch_pc_unit;

    localparam logic [31:0] LIMIT   = 32'h0000_07FC;
    localparam int          CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall;
    logic        branch;
    logic [31:0] targetOffset;
    logic        resolveValid;
    logic        resolveTaken;
    logic        resolvePredicted;
    logic [31:0] resolveTarget;
    logic [31:0] resolvePcPlus4;
    logic [31:0] address;
    logic [31:0] pcPlus4;
    logic        predicted;
    logic        flush;
    logic        halted;
    logic [15:0] mispredictCount;

    int checkCount = 0;
    int failCount  = 0;

    // Model: 0 = boot, 1 = run, 2 = halt
    int          mMode;
    logic [31:0] mPc;
    int          mCnt;

    fetch_pc_unit dut (
        .clk              (clk),
        .rst_n            (rstN),
        .stall            (stall),
        .branch           (branch),
        .target_offset    (targetOffset),
        .resolve_valid    (resolveValid),
        .resolve_taken    (resolveTaken),
        .resolve_predicted(resolvePredicted),
        .resolve_target   (resolveTarget),
        .resolve_pc_plus4 (resolvePcPlus4),
        .address          (address),
        .pc_plus4         (pcPlus4),
        .predicted        (predicted),
        .flush            (flush),
        .halted           (halted),
        .mispredict_count (mispredictCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setIdle();
        stall            = 1'b0;
        branch           = 1'b0;
        targetOffset     = 32'd0;
        resolveValid     = 1'b0;
        resolveTaken     = 1'b0;
        resolvePredicted = 1'b0;
        resolveTarget    = 32'd0;
        resolvePcPlus4   = 32'd0;
    endtask

    task automatic applyStimulus();
        stall            = ($urandom_range(0, 4) == 0);
        branch           = $urandom_range(0, 1) == 1;
        targetOffset     = $urandom_range(0, 16) - 8;
        resolveValid     = ($urandom_range(0, 3) == 0);
        resolveTaken     = $urandom_range(0, 1) == 1;
        resolvePredicted = $urandom_range(0, 1) == 1;
        resolveTarget    = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h7FF);
        resolvePcPlus4   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h7FF);
    endtask

    task automatic modelReset();
        mMode = 0;
        mPc   = 32'd0;
        mCnt  = 0;
    endtask

    // Starts at posedge+1: checks mid-cycle, then advances the model over the next edge.
    task automatic stepCycle();
        logic        mis;
        logic        expPred;
        logic        expFlush;
        logic [31:0] tgt;
        logic [31:0] seq;
        int          nMode;
        logic [31:0] nPc;
        int          nCnt;
        #3;
        mis = resolveValid && (resolveTaken != resolvePredicted);
`ifdef FETCH_PREDICT_TAKEN_EN
        expPred = branch && (mMode == 1);
`else
        expPred = 1'b0;
`endif
        expFlush = (mMode != 0) && mis;
        checkOutput("address", address, mPc);
        checkOutput("pcPlus4", pcPlus4, mPc + 32'd4);
        checkOutput("predicted", {31'd0, predicted}, {31'd0, expPred});
        checkOutput("flush", {31'd0, flush}, {31'd0, expFlush});
        checkOutput("halted", {31'd0, halted}, (mMode == 2) ? 32'd1 : 32'd0);
        checkOutput("count", {16'd0, mispredictCount}, mCnt);

        tgt   = (resolveTaken ? resolveTarget : resolvePcPlus4) & ~32'd3;
        seq   = mPc + 32'd4 + (expPred ? targetOffset * 32'd4 : 32'd0);
        nMode = mMode;
        nPc   = mPc;
        if (mMode == 0) begin
            nMode = 1;
        end else if (mMode == 1) begin
            if (mis) nPc = tgt;
            else if (!stall) begin
                if (seq > LIMIT) nMode = 2;
                else nPc = seq;
            end
        end else if (mis && tgt <= LIMIT) begin
            nPc   = tgt;
            nMode = 1;
        end
        nCnt = (expFlush && mCnt < CNT_MAX) ? mCnt + 1 : mCnt;
        @(posedge clk);
        #1;
        mMode = nMode;
        mPc   = nPc;
        mCnt  = nCnt;
    endtask

    task automatic redirect(input logic [31:0] target);
        setIdle();
        resolveValid  = 1'b1;
        resolveTaken  = 1'b1;
        resolveTarget = target;
        stepCycle();
    endtask

    initial begin
        rstN = 1'b0;
        setIdle();
        branch           = 1'b1;
        resolveValid     = 1'b1;
        resolveTaken     = 1'b1;
        resolveTarget    = 32'h100;
        modelReset();
        @(negedge clk);
        checkOutput("rst_address", address, 32'd0);
        checkOutput("rst_flush", {31'd0, flush}, 32'd0);
        checkOutput("rst_predicted", {31'd0, predicted}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_count", {16'd0, mispredictCount}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        setIdle();

        // Boot holds address 0 for two cycles, then sequential fetch.
        checkOutput("boot_addr0", address, 32'h0);
        stepCycle(); checkOutput("boot_addr1", address, 32'h0);
        stepCycle(); checkOutput("seq_addr4", address, 32'h4);
        stepCycle(); checkOutput("seq_addr8", address, 32'h8);
        stepCycle(); checkOutput("seq_addrC", address, 32'hC);

        branch       = 1'b1;
        targetOffset = 32'h3;
`ifdef FETCH_PREDICT_TAKEN_EN
        stepCycle(); checkOutput("pred_taken", address, 32'h1C);
        targetOffset = 32'hFFFF_FFFF;
        stepCycle(); checkOutput("self_loop", address, 32'h1C);
`else
        stepCycle(); checkOutput("nopred_seq", address, 32'h10);
        redirect(32'h1C); checkOutput("nopred_redirect", address, 32'h1C);
`endif

        // Mispredict overrides stall.
        setIdle();
        stall            = 1'b1;
        resolveValid     = 1'b1;
        resolvePredicted = 1'b1;
        resolvePcPlus4   = 32'h20;
        stepCycle();
        checkOutput("stall_redirect", address, 32'h20);
`ifdef FETCH_PREDICT_TAKEN_EN
        checkOutput("stall_count", {16'd0, mispredictCount}, 32'd1);
`else
        checkOutput("stall_count", {16'd0, mispredictCount}, 32'd2);
`endif

        for (int i = 0; i < 3000; i++) begin
            applyStimulus();
            stepCycle();
        end

        // Run off the end of the text segment, then recover.
        redirect(32'h7F0);
        setIdle();
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("halt_addr", address, 32'h7FC);
        checkOutput("halt_flag", {31'd0, halted}, 32'd1);
        redirect(32'h900);
        checkOutput("halt_oob_addr", address, 32'h7FC);
        checkOutput("halt_oob_flag", {31'd0, halted}, 32'd1);
        redirect(32'h40);
        checkOutput("unhalt_addr", address, 32'h40);
        checkOutput("unhalt_flag", {31'd0, halted}, 32'd0);

        // Saturate the mispredict counter.
        setIdle();
        resolveValid  = 1'b1;
        resolveTaken  = 1'b1;
        resolveTarget = 32'h40;
        for (int i = 0; i < 65539; i++) stepCycle();
        checkOutput("count_sat", {16'd0, mispredictCount}, 32'h0000_FFFF);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_address", address, 32'd0);
        checkOutput("async_count", {16'd0, mispredictCount}, 32'd0);
        checkOutput("async_flush", {31'd0, flush}, 32'd0);
        checkOutput("async_halted", {31'd0, halted}, 32'd0);
        checkOutput("async_predicted", {31'd0, predicted}, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int i = 0; i < 500; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
